spi_frame_master: RTL and testbench
===================================

Name: spi_frame_master

Overview:
- Full-duplex SPI master that moves one fixed-width frame per transaction to/from the AES SPI slave.
- On a start pulse it latches a FRAME_W-bit word and shifts it out MSB-first on mosi while capturing miso into data_out.
- The system controller uses it to send {plaintext/ciphertext 128, key_size 8, key 256} and to read back the result.
- The result sits in data_out[383:256].

Parameters:
- FRAME_W, 392: bits per transaction.
- CLK_DIV, 2: clk cycles per sclk half-period; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a transaction; sampled only in IDLE.
- buzy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when a transaction completes.
- data_in  in  FRAME_W  frame to transmit; latched on the accepted start.
- data_out  out  FRAME_W  last received frame; held until the next done.
- cs  out  1  slave select, active-low.
- mosi  out  1  serial data to the slave.
- miso  in  1  serial data from the slave.
- sclk  out  1  serial clock; idles low (SPI mode 0).

Behaviour:
- Reset (reset=0, asynchronous), all outputs forced immediately:
  - state=IDLE, cs=1, sclk=0, mosi=0, buzy=0, done=0, data_out=0.
  - Internal counters and shift registers cleared.
- States are IDLE, SHIFT, FINISH.
- IDLE:
  - cs=1, sclk=0, buzy=0.
  - On a clk edge with start=1: tx_sr←data_in, bit count←0, divider←0, go to SHIFT.
  - In the following cycle: cs=0, buzy=1, mosi=data_in[FRAME_W-1].
- SHIFT:
  - Divider counts clk cycles; every CLK_DIV cycles sclk toggles.
  - Rising sclk edge: rx_sr←{rx_sr[FRAME_W-2:0], miso}; bit count increments.
  - Falling sclk edge: tx_sr shifts left one bit; mosi←next MSB.
  - After the FRAME_W-th falling edge (2·FRAME_W toggles), sclk is back at 0; go to FINISH.
- FINISH, one cycle:
  - data_out←rx_sr, done=1, cs=1, buzy=0.
  - Next cycle: IDLE.
- Latency: done is high exactly 2·CLK_DIV·FRAME_W+1 clk cycles after the cycle in which start was sampled; 1569 cycles with the defaults.
- start while buzy=1 or in FINISH is ignored; it is not queued.
- start may be asserted in the cycle right after done; the new transaction is accepted.
- data_in changes after acceptance have no effect on the frame in flight.
- data_out is stable between done pulses; a partially received frame is never visible.
- Reset mid-transfer:
  - Aborts immediately; cs=1, sclk=0.
  - data_out is cleared; no done pulse is generated.
- mosi holds its last value when cs=1. The slave ignores mosi/sclk while cs=1.
- Bit order is MSB-first in both directions. Received bit k of the frame lands at data_out[FRAME_W-1-k].

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - miso is ignored; the receive path samples the internal mosi.
  - data_out equals the transmitted data_in at done; cs/sclk/mosi still toggle on the pins.
- SPI_LOOPBACK_EN undefined: normal operation; the receive path samples the miso pin.

Test Plan:
- Reset values: hold reset=0 for 5 cycles → cs=1, sclk=0, buzy=0, done=0, data_out=0. Release reset → all still idle with start=0.
- Single frame, slave model returns 392'h0A_dda97ca4864cdfe06eaf70a0ec0d7191_<256'h0>:
  - Stimulus: data_in={128'h00112233445566778899aabbccddeeff, 8'h18, 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000}, start pulse.
  - Captured mosi stream equals data_in, MSB first.
  - data_out[383:256]=128'hdda97ca4864cdfe06eaf70a0ec0d7191.
  - done is a one-cycle pulse 1569 cycles after start.
  - Exactly 392 sclk rising edges occur while cs=0.
- Start during busy: pulse start at cycles 100 and 800 of a transfer → no restart; single done pulse; sclk edge count stays 392.
- Back-to-back: four transactions, each start issued the cycle after the previous done:
  - Each is accepted; cs returns high for at least 1 cycle between frames.
  - data_out updates only on each done.
- Reset mid-transfer: assert reset at bit 200 → cs=1 and sclk=0 immediately; no done. After release, a new start completes normally.
- SPI_LOOPBACK_EN build: data_in=392'h1 then data_in={392{1'b1}} → data_out equals data_in after each done; miso held X has no effect.

Source files
------------

// File: rtl/spi_frame_master.sv
// Full-duplex SPI mode-0 master moving one FRAME_W-bit frame per transaction, MSB first.
// Optional SPI_LOOPBACK_EN: the receive path samples the internal mosi instead of the miso pin.
module spi_frame_master #(
  parameter int FRAME_W = 392,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               buzy,
  output logic               done,
  input  logic [FRAME_W-1:0] data_in,
  output logic [FRAME_W-1:0] data_out,
  output logic               cs,
  output logic               mosi,
  input  logic               miso,
  output logic               sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_r;
  logic [FRAME_W-1:0] tx_sr_r;
  logic [FRAME_W-1:0] rx_sr_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [DIV_W-1:0]   div_r;
  logic               tick_s;
  logic               rx_bit_s;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso_s;
  assign unused_miso_s = miso;
  assign rx_bit_s      = mosi;
`else
  assign rx_bit_s      = miso;
`endif

  // sclk half-period elapses when the divider reaches its last count
  assign tick_s = (div_r == DIV_W'(CLK_DIV - 1));

  // Transaction FSM with all pin outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      buzy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= {FRAME_W{1'b0}};
      tx_sr_r   <= {FRAME_W{1'b0}};
      rx_sr_r   <= {FRAME_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      div_r     <= {DIV_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          cs   <= 1'b1;
          sclk <= 1'b0;
          buzy <= 1'b0;
          if (start) begin
            tx_sr_r   <= data_in;
            bit_cnt_r <= {CNT_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            mosi      <= data_in[FRAME_W-1];
            cs        <= 1'b0;
            buzy      <= 1'b1;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
            sclk  <= ~sclk;
            if (!sclk) begin
              // rising edge: sample the slave's bit
              rx_sr_r   <= {rx_sr_r[FRAME_W-2:0], rx_bit_s};
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
              // falling edge: present the next bit; the last one ends the frame
              tx_sr_r <= {tx_sr_r[FRAME_W-2:0], 1'b0};
              mosi    <= tx_sr_r[FRAME_W-2];
              if (bit_cnt_r == CNT_W'(FRAME_W)) begin
                state_r <= FINISH;
              end
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        FINISH: begin
          data_out <= rx_sr_r;
          done     <= 1'b1;
          cs       <= 1'b1;
          buzy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed self-checking bench for spi_frame_master with a mode-0 slave model.
module tb_spi_frame_master;
  localparam int FW = 392;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic          miso;
  logic          buzy, done, cs, mosi, sclk;
  logic [FW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] resp = '0;
  logic [FW-1:0] cap;
  int            rise_cnt;
  int            done_cnt = 0;

  spi_frame_master dut (
    .clk(clk), .reset(reset), .start(start), .buzy(buzy), .done(done),
    .data_in(data_in), .data_out(data_out), .cs(cs), .mosi(mosi),
    .miso(miso), .sclk(sclk)
  );

  always #5 clk = ~clk;

  // Slave model: restart on cs falling, capture mosi on each rising sclk while selected
  always @(negedge cs or posedge sclk) begin
    if (sclk == 1'b0) begin
      cap      = '0;
      rise_cnt = 0;
    end else if (cs == 1'b0) begin
      cap      = {cap[FW-2:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

`ifdef SPI_LOOPBACK_EN
  assign miso = 1'bx;
`else
  assign miso = (rise_cnt < FW) ? resp[FW-1-rise_cnt] : 1'b0;
`endif

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic [FW-1:0] exp_rx(input logic [FW-1:0] din);
`ifdef SPI_LOOPBACK_EN
    return din;
`else
    return resp;
`endif
  endfunction

  // One transaction; start issued at the next falling clk edge, returns in the done cycle.
  task automatic run_frame(input logic [FW-1:0] din, input bit busy_pulses,
                           output int lat, output bit dout_moved);
    logic [FW-1:0] prev;
    prev = data_out;
    lat = 0;
    dout_moved = 1'b0;
    @(negedge clk);
    data_in = din;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    data_in = ~din;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk);
      #1 start = busy_pulses && (n == 100 || n == 800);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (data_out !== prev) dout_moved = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (buzy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_buzy_done: got %b%b want 00", buzy, done); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({cs, sclk, buzy, done} !== 4'b1000) begin errors++; $display("FAIL post_reset_idle: got %b want 1000", {cs, sclk, buzy, done}); end
  endtask

  task automatic test_single();
    logic [FW-1:0] din;
    logic [FW-1:0] exp;
    int lat;
    bit moved;
    resp = {8'h0A, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 256'h0};
    din  = {128'h00112233445566778899aabbccddeeff, 8'h18,
            192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    exp  = exp_rx(din);
    run_frame(din, 1'b0, lat, moved);
    checks++; if (lat !== 1569) begin errors++; $display("FAIL single_latency: got %0d want 1569", lat); end
    checks++; if (data_out[383:256] !== exp[383:256]) begin errors++; $display("FAIL single_result: got %h want %h", data_out[383:256], exp[383:256]); end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL single_data_out: got %h want %h", data_out, exp); end
    checks++; if (cap !== din) begin errors++; $display("FAIL single_mosi_stream: got %h want %h", cap, din); end
    checks++; if (rise_cnt !== FW) begin errors++; $display("FAIL single_sclk_edges: got %0d want %0d", rise_cnt, FW); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL single_data_out_early: got %b want 0", moved); end
    checks++; if ({cs, buzy} !== 2'b10) begin errors++; $display("FAIL single_done_cycle_pins: got %b want 10", {cs, buzy}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_start_busy();
    logic [FW-1:0] din;
    logic [FW-1:0] exp;
    int lat, d0;
    bit moved;
    din  = {49{8'hC3}};
    resp = {49{8'h5A}};
    exp  = exp_rx(din);
    d0   = done_cnt;
    run_frame(din, 1'b1, lat, moved);
    repeat (6) @(negedge clk);
    checks++; if (lat !== 1569) begin errors++; $display("FAIL busy_latency: got %0d want 1569", lat); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (rise_cnt !== FW) begin errors++; $display("FAIL busy_sclk_edges: got %0d want %0d", rise_cnt, FW); end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL busy_data_out: got %h want %h", data_out, exp); end
    checks++; if (buzy !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got %b want 0", buzy); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] din;
    logic [FW-1:0] exp;
    logic [7:0] b;
    int lat;
    bit moved;
    for (int i = 0; i < 4; i++) begin
      b    = 8'(i * 37 + 5);
      din  = {49{b}};
      resp = {49{~b}};
      exp  = exp_rx(din);
      run_frame(din, 1'b0, lat, moved);
      checks++; if (lat !== 1569) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 1569", i, lat); end
      checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_data_out[%0d]: got %h want %h", i, data_out, exp); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL b2b_data_out_early[%0d]: got %b want 0", i, moved); end
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL b2b_cs_gap[%0d]: got %b want 1", i, cs); end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] din;
    logic [FW-1:0] exp;
    int lat, d0;
    bit moved, reached;
    din  = {49{8'h96}};
    resp = {49{8'h3C}};
    reached = 1'b0;
    @(negedge clk);
    data_in = din;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rise_cnt >= 200) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL mid_reach_bit200: got %0d edges want 200", rise_cnt); end
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    checks++; if ({cs, sclk, buzy} !== 3'b100) begin errors++; $display("FAIL mid_abort_pins: got %b want 100", {cs, sclk, buzy}); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_data_out_cleared: got %h want 0", data_out); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
    exp = exp_rx(din);
    run_frame(din, 1'b0, lat, moved);
    checks++; if (lat !== 1569) begin errors++; $display("FAIL mid_restart_latency: got %0d want 1569", lat); end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL mid_restart_data_out: got %h want %h", data_out, exp); end
  endtask

  task automatic test_patterns();
    logic [FW-1:0] din;
    int lat;
    bit moved;
    for (int i = 0; i < 2; i++) begin
      din  = (i == 0) ? {{(FW-1){1'b0}}, 1'b1} : {FW{1'b1}};
      resp = din;
      run_frame(din, 1'b0, lat, moved);
      checks++; if (data_out !== din) begin errors++; $display("FAIL pattern_data_out[%0d]: got %h want %h", i, data_out, din); end
      checks++; if (cap !== din) begin errors++; $display("FAIL pattern_mosi[%0d]: got %h want %h", i, cap, din); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_patterns();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
